bin2bcd: RTL and testbench
==========================

BIN2BCD -- requirements
Module: bin2bcd

Interface
REQ-001 Parameter BIN_W, default 14, binary input width.
REQ-002 Parameter N_DIGITS, default 4, number of BCD output digits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a conversion; sampled only in IDLE.
REQ-006 bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
REQ-007 bcd  output  4*N_DIGITS  registered result; digit 0 (units) in bits [3:0], most significant digit on top; each nibble drives one bcd7seg instance.
REQ-008 busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-009 done  output  1  one-cycle pulse; bcd is valid in the same cycle.
REQ-010 ovf  output  1  registered; high when the last accepted bin exceeded 10^N_DIGITS-1.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; exactly one transition path IDLE->SHIFT->DONE->IDLE.
REQ-012 Edge E0, in IDLE with start=1: capture bin into the shift register, clear the BCD scratch, clear the bit counter, and enter SHIFT.
REQ-013 SHIFT performs double-dabble: each edge, add 3 to every scratch digit >= 5, then shift {scratch, bin_reg} left by one.
REQ-014 SHIFT lasts exactly BIN_W edges (E1..E_BIN_W); on edge E_BIN_W the FSM loads bcd and enters DONE.
REQ-015 done = 1 for exactly the cycle following edge E_BIN_W (DONE state); FSM returns to IDLE on the next edge.
REQ-016 Fixed latency: done occurs BIN_W edges after the accepting edge, independent of the value converted.
REQ-017 busy = 1 from the cycle after E0 through the DONE cycle inclusive; busy = 0 in IDLE.
REQ-018 start while busy = 1 (SHIFT or DONE) is ignored; no queuing, no effect on the conversion in progress.
REQ-019 start held high continuously causes back-to-back conversions, each accepted in the first IDLE cycle.
REQ-020 Overflow: bin > 10^N_DIGITS-1 sets ovf on acceptance; at DONE, bcd is loaded with all nibbles 4'hF (blank on display); timing is identical to a normal conversion.
REQ-021 In-range conversion clears ovf on acceptance.
REQ-022 bcd and ovf hold their last value between done pulses; intermediate scratch values never appear on bcd.
REQ-023 The bit counter is sized ceil(log2(BIN_W+1)) bits and does not wrap during a conversion.

Reset
REQ-024 reset = 1 at an edge forces IDLE and sets bcd = 0 (display "0000"), busy = 0, done = 0, ovf = 0, with the counter and scratch cleared.
REQ-025 reset during SHIFT or DONE aborts the conversion; no done pulse follows.
REQ-026 reset has priority over start in the same cycle.

Structure
REQ-027 Shared package holds the state enum (IDLE/SHIFT/DONE), BIN_W and N_DIGITS defaults, and MAX_VAL = 10^N_DIGITS-1.
REQ-028 One combinational sub-module, bcd_add3 (4-bit in, 4-bit out, +3 when >= 5), is instantiated N_DIGITS times.
REQ-029 No other sub-modules; the FSM, counter and shift register are in bin2bcd.

Verification
REQ-030 bin=0, start pulse at E0 -> done is high in exactly the cycle after E14, bcd=16'h0000, ovf=0.
REQ-031 bin=1234 -> bcd=16'h1234; bin=9999 -> bcd=16'h9999; bcd holds until the next done.
REQ-032 bin=10000 -> ovf=1, bcd=16'hFFFF at done; a following bin=42 -> ovf=0, bcd=16'h0042.
REQ-033 start=1 with bin=5555 at E3 of a conversion of 777 -> only one done, bcd=16'h0777, busy continuous.
REQ-034 reset asserted at E7 of a conversion -> no done, busy=0 and bcd=16'h0000 after the edge; a new start converts correctly.
REQ-035 start held high with bin=8 -> done pulses repeat with a period of BIN_W+2 cycles, each with bcd=16'h0008.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared definitions for the binary-to-BCD converter.
//   - state_t      : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEF_BIN_W    : default binary input width
//   - DEF_N_DIGITS : default number of BCD digits
//   - MAX_VAL      : largest value representable with DEF_N_DIGITS digits
//   - max_val()    : 10^n - 1 for an arbitrary digit count
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_BIN_W    = 14;
  localparam int DEF_N_DIGITS = 4;

  // 10^n_digits - 1, evaluated at elaboration time for the overflow limit.
  function automatic logic [63:0] max_val(input int n_digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n_digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DEF_N_DIGITS);

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction.
// Ports:
//   din  [3:0] - BCD scratch digit before the shift
//   dout [3:0] - din + 3 when din >= 5, otherwise din unchanged
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-correct the digit so that the following left shift carries into the next decade.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   start - conversion request, honoured only while idle
//   bin   - unsigned binary value, captured on the accepting edge
//   bcd   - registered result, digit 0 (units) in bits [3:0]
//   busy  - high from the cycle after acceptance through the done cycle
//   done  - one-cycle pulse, bcd valid in the same cycle
//   ovf   - registered, set when the accepted value exceeds 10^N_DIGITS-1
// A conversion always takes BIN_W shift edges; an out-of-range value still
// runs the full sequence and then loads all-F nibbles (blank display).
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W    = DEF_BIN_W,
  parameter int N_DIGITS = DEF_N_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0]      MAX_V    = max_val(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state_r;
  logic [BIN_W-1:0]   bin_r;
  logic [BCD_W-1:0]   scratch_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               busy_r;
  logic               done_r;
  logic               ovf_r;

  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   scratch_nxt_s;
  logic               ovf_s;

  // Per-digit add-3 correction applied before every shift.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (scratch_r[4*i +: 4]),
      .dout (adj_s[4*i +: 4])
    );
  end

  // Next scratch value: corrected digits shifted left, binary MSB shifted in.
  always_comb begin
    scratch_nxt_s = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
  end

  // Range check on the raw input, used only on the accepting edge.
  always_comb begin
    ovf_s = (64'(bin) > MAX_V);
  end

  // Conversion FSM, bit counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bin_r     <= {BIN_W{1'b0}};
      scratch_r <= {BCD_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      bcd_r     <= {BCD_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            bin_r     <= bin;
            scratch_r <= {BCD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= ovf_s;
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          scratch_r <= scratch_nxt_s;
          bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
          // Counter ends at BIN_W, which fits in CNT_W bits, so it never wraps.
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            bcd_r   <= ovf_r ? {BCD_W{1'b1}} : scratch_nxt_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd  = bcd_r;
  assign busy = busy_r;
  assign done = done_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: scoreboard bench for bin2bcd (BIN_W=14, N_DIGITS=4).
// Expected results are queued when a conversion is started and compared
// by a monitor when done pulses, including the exact done cycle.
module tb_bin2bcd;

  localparam int BIN_W = 14;
  localparam int PERIOD = BIN_W + 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc;
  int          chk_cnt;
  int          err_cnt;
  int          done_cnt;
  logic [15:0] last_bcd;

  bin2bcd #(.BIN_W(14), .N_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time the done pulse against the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference conversion from decimal arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          t;
    if (v > 9999) return 16'hFFFF;
    r = 16'h0000;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_bcd", 32'(bcd), 32'(e.bcd));
        check("done_ovf", 32'(ovf), 32'(e.ovf));
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("busy_at_done", 32'(busy), 32'd1);
        done_cnt++;
      end
    end
  end

  // One conversion; optionally inject a start (inject_at) or a reset (reset_at)
  // at the negedge preceding edge E(index+1).
  task automatic run_conv(input int v, input int inject_at = -1, input int reset_at = -1);
    int   k;
    exp_t e;
    @(negedge clk);
    k     = cyc;
    bin   = 14'(v);
    start = 1'b1;
    e.bcd = ref_bcd(v);
    e.ovf = (v > 9999);
    e.due = k + 1 + BIN_W;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom_range(0, 16383));
    for (int i = 0; i <= BIN_W; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      if (i == 0) check("ovf_accept", 32'(ovf), 32'(e.ovf));
      if (i < BIN_W) check("bcd_hold", 32'(bcd), 32'(last_bcd));
      if (i == inject_at) begin
        start = 1'b1;
        bin   = 14'd5555;
      end else begin
        start = 1'b0;
      end
      if (i == reset_at) reset = 1'b1;
      @(negedge clk);
      if (i == reset_at) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        void'(sb_q.pop_back());
        last_bcd = 16'h0000;
        return;
      end
    end
    check("busy_idle", 32'(busy), 32'd0);
    last_bcd = e.bcd;
  endtask

  initial begin
    int   k;
    int   n0;
    exp_t e;
    cyc      = 0;
    chk_cnt  = 0;
    err_cnt  = 0;
    done_cnt = 0;
    last_bcd = 16'h0000;
    reset    = 1'b1;
    start    = 1'b1;
    bin      = 14'd1234;
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_conv(0);
    run_conv(1234);
    run_conv(9999);
    repeat (5) @(negedge clk);
    check("bcd_hold_idle", 32'(bcd), 32'h9999);
    check("ovf_hold_idle", 32'(ovf), 32'd0);
    run_conv(10000);
    run_conv(42);
    run_conv(16383);
    run_conv(7);

    // start with 5555 sampled at E3 of the 777 conversion must be ignored
    run_conv(777, 2);
    repeat (20) @(negedge clk);
    check("after_inject_bcd", 32'(bcd), 32'h0777);

    // reset at E7 aborts; no done may follow
    run_conv(3210, -1, 6);
    repeat (20) @(negedge clk);
    check("abort_bcd", 32'(bcd), 32'h0000);
    run_conv(4321);

    // start held high: back-to-back conversions every BIN_W+2 cycles
    @(negedge clk);
    n0    = done_cnt;
    k     = cyc;
    bin   = 14'd8;
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      e.bcd = 16'h0008;
      e.ovf = 1'b0;
      e.due = k + 1 + j * PERIOD + BIN_W;
      sb_q.push_back(e);
    end
    while (cyc < k + 1 + 2 * PERIOD + BIN_W) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_count", 32'(done_cnt - n0), 32'd3);
    check("b2b_bcd", 32'(bcd), 32'h0008);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
